// File: rtl/color_reconstruct.sv
// Rebuilds 8-bit color from a 4-bit dithered stream with a per-line moving average.
// Define COLOR_RECON_FILTER_EN to build the averaging filter; otherwise the nibble is replicated.
module color_reconstruct #(
  parameter int N_TAPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] entrada_color_4_bit,
  input  logic       visible,
  output logic [7:0] salida_color_8_bit,
  output logic       salida_valida
);

  if (!(N_TAPS == 2 || N_TAPS == 4 || N_TAPS == 8)) begin : g_bad_taps
    $error("color_reconstruct: N_TAPS must be 2, 4 or 8");
  end

  typedef enum logic {IDLE, LINE} state_t;

  state_t     state_q, state_d;
  logic [7:0] color_q, color_d;
  logic       valid_q, valid_d;
  logic       line_start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (visible)  state_d = LINE;
      LINE:    if (!visible) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign line_start = (state_q == IDLE) && visible;
  assign valid_d    = visible;

`ifdef COLOR_RECON_FILTER_EN
  localparam int LOG2   = $clog2(N_TAPS);
  localparam int SUM_W  = 4 + LOG2;
  localparam int PROD_W = SUM_W + 5;

  logic [3:0]       win_q [N_TAPS];
  logic [3:0]       win_d [N_TAPS];
  logic [SUM_W-1:0] sum_q, sum_d;

  // Round-to-nearest of sum*17/N_TAPS; never exceeds 255 so truncation to 8 bits is exact.
  function automatic logic [7:0] expand(input logic [SUM_W-1:0] s);
    logic [PROD_W-1:0] p;
    p = PROD_W'(s) * PROD_W'(17) + PROD_W'(N_TAPS / 2);
    return 8'(p >> LOG2);
  endfunction

  always_comb begin
    win_d = win_q;
    sum_d = sum_q;
    if (line_start) begin
      for (int i = 0; i < N_TAPS; i++) win_d[i] = entrada_color_4_bit;
      sum_d = SUM_W'(entrada_color_4_bit) << LOG2;
    end else if (visible) begin
      win_d[0] = entrada_color_4_bit;
      for (int i = 1; i < N_TAPS; i++) win_d[i] = win_q[i-1];
      sum_d = sum_q + SUM_W'(entrada_color_4_bit) - SUM_W'(win_q[N_TAPS-1]);
    end
    color_d = visible ? expand(sum_d) : 8'h00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) win_q[i] <= 4'h0;
      sum_q <= '0;
    end else begin
      win_q <= win_d;
      sum_q <= sum_d;
    end
  end
`else
  always_comb begin
    color_d = visible ? {entrada_color_4_bit, entrada_color_4_bit} : 8'h00;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      color_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      color_q <= color_d;
      valid_q <= valid_d;
    end
  end

  assign salida_color_8_bit = color_q;
  assign salida_valida      = valid_q;

endmodule
